// File: rtl/snn_loader_pkg.sv
// Shared definitions for the spiking-NN parameter stream loader: FSM encoding,
// header id field width helper and the default SIPO channel map.
package snn_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    localparam int CH_W    = 0;
    localparam int CH_BETA = 1;
    localparam int CH_TETA = 2;
    localparam int CH_BNF  = 3;
    localparam int CH_BNA  = 4;
    localparam int CH_IN   = 5;

    // A single-channel build still carries a one-bit id so ports keep a legal width.
    function automatic int id_field_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/snn_word_serializer.sv
// Splits one IN_W-bit stream word into IN_W/SHIFT_W chunks, LSB chunk first,
// with a per-chunk keep mask so chunks past the channel length are dropped.
module snn_word_serializer #(
    parameter int IN_W    = 8,
    parameter int SHIFT_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [IN_W-1:0]    load_data,
    input  logic               keep,
    input  logic               flush,
    output logic [SHIFT_W-1:0] chunk_data,
    output logic               chunk_ce,
    output logic               ready,
    output logic               issue
);
    localparam int CW = $clog2(IN_W / SHIFT_W) + 1;
    localparam logic [CW-1:0] R_C = CW'(IN_W / SHIFT_W);

    logic [IN_W-1:0] data_r;
    logic [CW-1:0]   cnt_r;
    logic            ce_r;

    // A chunk is issued on a load or while more than the current chunk remains.
    assign issue      = load | (cnt_r > CW'(1));
    assign ready      = (cnt_r <= CW'(1));
    assign chunk_data = data_r[SHIFT_W-1:0];
    assign chunk_ce   = ce_r;

    // Holding register shifts toward the LSB so the live chunk is always bits [SHIFT_W-1:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= {IN_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            ce_r   <= 1'b0;
        end else if (flush) begin
            data_r <= {IN_W{1'b0}};
            cnt_r  <= {CW{1'b0}};
            ce_r   <= 1'b0;
        end else begin
            ce_r <= issue & keep;
            if (load) begin
                data_r <= load_data;
                cnt_r  <= R_C;
            end else if (cnt_r != {CW{1'b0}}) begin
                data_r <= data_r >> SHIFT_W;
                cnt_r  <= cnt_r - CW'(1);
            end
        end
    end

endmodule

// File: rtl/snn_param_stream_loader.sv
// Packetised parameter loader: header selects a SIPO channel, payload words are
// serialised onto shift_data with a one-hot shift_ce. Optional feature macro:
// SNN_LOADER_CHECKSUM_EN adds a trailing XOR checksum word per packet.
module snn_param_stream_loader
    import snn_loader_pkg::*;
#(
    parameter int                          IN_W     = 8,
    parameter int                          SHIFT_W  = 2,
    parameter int                          NUM_CH   = 6,
    parameter int                          LEN_W    = 24,
    parameter logic [NUM_CH*LEN_W-1:0]     CH_BEATS = {NUM_CH{24'd8}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IN_W-1:0]    in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               clear,
    output logic [SHIFT_W-1:0] shift_data,
    output logic [NUM_CH-1:0]  shift_ce,
    output logic               busy,
    output logic [NUM_CH-1:0]  loaded,
    output logic               err_bad_id,
    output logic               err_checksum
);
    localparam int IDW = id_field_w(NUM_CH);
    localparam logic [LEN_W-1:0] R_L   = LEN_W'(IN_W / SHIFT_W);
    localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

    state_t             state_r, state_s;
    logic               run_r;
    logic [IDW-1:0]     ch_r, hdr_id_s;
    logic [LEN_W-1:0]   rem_r, pend_r, beats_s;
    logic [NUM_CH-1:0]  loaded_r, loaded_s, hdr_oh_s, ch_oh_s;
    logic               err_bad_r;
    logic               id_bad_s, hdr_take_s, word_take_s, end_s, set_s, clr_s, keep_s;
    logic               in_ready_s;
    logic               ser_ready_s, ser_issue_s, ser_ce_s;
    logic [SHIFT_W-1:0] ser_data_s;

    generate
        if (NUM_CH > 1) begin : g_id
            assign hdr_id_s = in_data[IDW-1:0];
        end else begin : g_id0
            assign hdr_id_s = {IDW{1'b0}};
        end
    endgenerate

    assign id_bad_s = (32'(hdr_id_s) >= 32'(NUM_CH));
    assign clr_s    = (state_r == ST_IDLE) && clear;
    assign keep_s   = (state_r == ST_PAYLOAD) && (rem_r != {LEN_W{1'b0}});

    snn_word_serializer #(.IN_W(IN_W), .SHIFT_W(SHIFT_W)) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (word_take_s),
        .load_data  (in_data),
        .keep       (keep_s),
        .flush      (end_s),
        .chunk_data (ser_data_s),
        .chunk_ce   (ser_ce_s),
        .ready      (ser_ready_s),
        .issue      (ser_issue_s)
    );

    // Channel length lookup for the incoming header and one-hot decodes of header / latched id.
    always_comb begin
        beats_s  = {LEN_W{1'b0}};
        hdr_oh_s = {NUM_CH{1'b0}};
        ch_oh_s  = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (hdr_id_s == IDW'(c)) begin
                beats_s     = CH_BEATS[c*LEN_W +: LEN_W];
                hdr_oh_s[c] = 1'b1;
            end else begin
                hdr_oh_s[c] = 1'b0;
            end
            ch_oh_s[c] = (ch_r == IDW'(c));
        end
    end

`ifdef SNN_LOADER_CHECKSUM_EN
    logic [IN_W-1:0] xor_r;
    logic            err_chk_r, chk_take_s;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and handshake decode; packet ends after the last kept chunk has been shown.
    always_comb begin
        state_s     = state_r;
        in_ready_s  = 1'b0;
        hdr_take_s  = 1'b0;
        word_take_s = 1'b0;
        end_s       = 1'b0;
`ifdef SNN_LOADER_CHECKSUM_EN
        chk_take_s  = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                in_ready_s = run_r;
                hdr_take_s = in_valid & run_r;
                if (hdr_take_s && !id_bad_s) begin
                    state_s = ST_PAYLOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                in_ready_s  = ser_ready_s && (pend_r != {LEN_W{1'b0}});
                word_take_s = in_valid & in_ready_s;
                end_s       = (rem_r == {LEN_W{1'b0}}) && ser_ce_s;
                if (end_s) begin
`ifdef SNN_LOADER_CHECKSUM_EN
                    state_s = ST_CHECK;
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_PAYLOAD;
                end
            end
`ifdef SNN_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                in_ready_s = 1'b1;
                chk_take_s = in_valid;
                if (chk_take_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CHECK;
                end
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

`ifdef SNN_LOADER_CHECKSUM_EN
    assign set_s        = chk_take_s && (xor_r == in_data);
    assign err_checksum = err_chk_r;

    // Running XOR of payload words and sticky checksum error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_r     <= {IN_W{1'b0}};
            err_chk_r <= 1'b0;
        end else begin
            if (hdr_take_s && !id_bad_s) begin
                xor_r <= {IN_W{1'b0}};
            end else if (word_take_s) begin
                xor_r <= xor_r ^ in_data;
            end
            if (chk_take_s && (xor_r != in_data)) begin
                err_chk_r <= 1'b1;
            end else if (clr_s) begin
                err_chk_r <= 1'b0;
            end
        end
    end
`else
    assign set_s        = end_s;
    assign err_checksum = 1'b0;
`endif

    // Loaded flags: clear first, then a new header drops its own bit, then completion sets it.
    always_comb begin
        loaded_s = clr_s ? {NUM_CH{1'b0}} : loaded_r;
        loaded_s = (hdr_take_s && !id_bad_s) ? (loaded_s & ~hdr_oh_s) : loaded_s;
        loaded_s = set_s ? (loaded_s | ch_oh_s) : loaded_s;
    end

    // Packet counters, status flags and the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_r     <= 1'b0;
            ch_r      <= {IDW{1'b0}};
            rem_r     <= {LEN_W{1'b0}};
            pend_r    <= {LEN_W{1'b0}};
            loaded_r  <= {NUM_CH{1'b0}};
            err_bad_r <= 1'b0;
        end else begin
            run_r    <= 1'b1;
            loaded_r <= loaded_s;
            if (hdr_take_s && id_bad_s) begin
                err_bad_r <= 1'b1;
            end else if (clr_s) begin
                err_bad_r <= 1'b0;
            end
            if (hdr_take_s && !id_bad_s) begin
                ch_r   <= hdr_id_s;
                rem_r  <= beats_s;
                pend_r <= beats_s;
            end else begin
                if (ser_issue_s && keep_s) begin
                    rem_r <= rem_r - ONE_L;
                end
                // pend_r counts chunks not yet covered by an accepted word.
                if (word_take_s) begin
                    pend_r <= (pend_r > R_L) ? (pend_r - R_L) : {LEN_W{1'b0}};
                end
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign busy       = (state_r != ST_IDLE);
    assign loaded     = loaded_r;
    assign err_bad_id = err_bad_r;
    assign shift_data = ser_data_s;
    assign shift_ce   = ch_oh_s & {NUM_CH{ser_ce_s}};

endmodule
